// File: rtl/nf10_axis_pkt_gen_if.sv
// AXI4-Stream bundle carrying generated test frames toward the 10G TX port.
// The generator drives everything except tready; the consumer drives tready.
interface nf10_axis_pkt_gen_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tstrb,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/nf10_axis_pkt_gen.sv
// Transmit-side AXI4-Stream packet source for 10G bring-up and loopback.
// Emits numbered frames whose byte k carries (k + seq) mod 256, with NetFPGA
// tuser metadata {dst, src, len}, separated by a programmable idle gap.
// All stream outputs are decoded from registered state, so they stay stable
// while the consumer stalls and fall to zero the cycle after reset.
module nf10_axis_pkt_gen #(
    parameter int         C_M_AXIS_DATA_WIDTH  = 256,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0] C_DEFAULT_SRC_PORT   = 8'h00,
    parameter logic [7:0] C_DEFAULT_DST_PORT   = 8'h10
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [15:0]                pkt_len,
    input  logic [31:0]                pkt_count,
    input  logic [15:0]                gap_cycles,
    nf10_axis_pkt_gen_if.master        m_axis,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                pkts_sent
);

    localparam int BYTES = C_M_AXIS_DATA_WIDTH / 8;
    localparam int BW    = $clog2(BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Run configuration captured on an accepted start.
    logic [15:0] len_q;
    logic [31:0] count_q;
    logic [15:0] gap_q;

    // Per-packet and per-gap progress.
    logic [15:0] beat_idx;
    logic [15:0] gap_cnt;
    logic [31:0] pkts_sent_q;
    logic        stop_q;
    logic        done_q;

    // Derived control.
    logic [15:0]   last_idx;
    logic [BW-1:0] rem;
    logic          is_last;
    logic          beat_accept;
    logic          last_accept;
    logic          stop_pend;
    logic          run_end;
    logic          start_ok;
    logic          enter_idle;

    // Output beat assembly.
    logic [7:0]                          byte_base;
    logic [C_M_AXIS_DATA_WIDTH-1:0]      tdata_c;
    logic [BYTES-1:0]                    tstrb_c;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]     tuser_c;
    logic                                tvalid_c;
    logic                                tlast_c;

    // Handshake and end-of-run conditions shared by the FSM and datapath.
    always_comb begin
        last_idx    = (len_q - 16'd1) >> BW;
        rem         = len_q[BW-1:0];
        is_last     = (beat_idx == last_idx);
        beat_accept = (state == ST_SEND) && m_axis.tready;
        last_accept = beat_accept && is_last;
        // A stop pulse is remembered so it still ends the run at the next
        // packet boundary even if it has already dropped by then.
        stop_pend   = stop || stop_q;
        run_end     = ((count_q != 32'd0) && (pkts_sent_q + 32'd1 == count_q)) || stop_pend;
        start_ok    = (state == ST_IDLE) && start;
    end

    // State register.
    always_ff @(posedge axi_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (axi_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: packets follow each other directly, through a gap,
    // or return to IDLE once the count is reached or stop is pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_nxt  = state;
        enter_idle = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && (pkt_len != 16'd0)) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_accept) begin
                    if (run_end) begin
                        state_nxt  = ST_IDLE;
                        enter_idle = 1'b1;
                    end else if (gap_q != 16'd0) begin
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop_pend) begin
                    state_nxt  = ST_IDLE;
                    enter_idle = 1'b1;
                end else if (gap_cnt == 16'd0) begin
                    state_nxt = ST_SEND;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                enter_idle = 1'b1;
            end
        endcase
    end

    // Datapath registers: config capture, beat/gap counters, packet count,
    // pending stop and the done pulse.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            beat_idx    <= '0;
            gap_cnt     <= '0;
            pkts_sent_q <= '0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // An empty run finishes immediately with a done pulse and no beats.
            done_q <= enter_idle || (start_ok && (pkt_len == 16'd0));

            if (start_ok) begin
                len_q       <= pkt_len;
                count_q     <= pkt_count;
                gap_q       <= gap_cycles;
                beat_idx    <= '0;
                pkts_sent_q <= '0;
                stop_q      <= stop && (pkt_len != 16'd0);
            end else if (state != ST_IDLE) begin
                if (enter_idle) begin
                    stop_q <= 1'b0;
                end else if (stop) begin
                    stop_q <= 1'b1;
                end
            end

            if (beat_accept) begin
                if (is_last) begin
                    beat_idx    <= '0;
                    pkts_sent_q <= pkts_sent_q + 32'd1;
                    gap_cnt     <= gap_q - 16'd1;
                end else begin
                    beat_idx <= beat_idx + 16'd1;
                end
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end
        end
    end

    // Beat assembly: payload bytes count up from the packet sequence number,
    // and bytes past the frame length on the last beat are strobed off and zeroed.
    always_comb begin
        tdata_c   = '0;
        tstrb_c   = '0;
        tuser_c   = '0;
        tvalid_c  = 1'b0;
        tlast_c   = 1'b0;
        byte_base = 8'(beat_idx << BW) + pkts_sent_q[7:0];
        if (state == ST_SEND) begin
            tvalid_c      = 1'b1;
            tlast_c       = is_last;
            tuser_c[31:0] = {C_DEFAULT_DST_PORT, C_DEFAULT_SRC_PORT, len_q};
            for (int i = 0; i < BYTES; i++) begin
                if (!is_last || (rem == '0) || (BW'(i) < rem)) begin
                    tstrb_c[i]       = 1'b1;
                    tdata_c[8*i +: 8] = byte_base + 8'(i);
                end
            end
        end
    end

    assign m_axis.tdata  = tdata_c;
    assign m_axis.tstrb  = tstrb_c;
    assign m_axis.tuser  = tuser_c;
    assign m_axis.tvalid = tvalid_c;
    assign m_axis.tlast  = tlast_c;

    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign pkts_sent = pkts_sent_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed bench for nf10_axis_pkt_gen: reset state, single and multi-packet
// runs with gaps, random backpressure, stop in continuous mode, mid-frame
// reset, ignored start while busy, empty runs and start+stop together.
module tb_nf10_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        axi_reset;
    logic        start;
    logic        stop;
    logic [15:0] pkt_len;
    logic [31:0] pkt_count;
    logic [15:0] gap_cycles;
    logic        busy;
    logic        done;
    logic [31:0] pkts_sent;

    int tests = 0;
    int fails = 0;

    nf10_axis_pkt_gen_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_axis ();

    nf10_axis_pkt_gen #(
        .C_M_AXIS_DATA_WIDTH  (256),
        .C_M_AXIS_TUSER_WIDTH (128),
        .C_DEFAULT_SRC_PORT   (8'h00),
        .C_DEFAULT_DST_PORT   (8'h10)
    ) dut (
        .axi_aclk   (clk),
        .axi_reset  (axi_reset),
        .start      (start),
        .stop       (stop),
        .pkt_len    (pkt_len),
        .pkt_count  (pkt_count),
        .gap_cycles (gap_cycles),
        .m_axis     (m_axis.master),
        .busy       (busy),
        .done       (done),
        .pkts_sent  (pkts_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] len, input logic [31:0] cnt, input logic [15:0] gap);
        pkt_len    = len;
        pkt_count  = cnt;
        gap_cycles = gap;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    logic [255:0] pd;
    logic [31:0]  ps;
    logic [127:0] pu;
    logic         pl;
    logic         prev_stall;
    logic         prev_valid;
    logic         prev_end;
    logic         done_seen;
    int           beats;
    int           pkt_idx;

    initial begin
        axi_reset     = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        pkt_len       = 16'd0;
        pkt_count     = 32'd0;
        gap_cycles    = 16'd0;
        m_axis.tready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_tvalid", m_axis.tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pkts", pkts_sent, 32'd0);
        check("rst_tdata", m_axis.tdata, 256'd0);
        axi_reset = 1'b0;
        tick();

        // T1: 64 bytes, one packet, no gap
        pulse_start(16'd64, 32'd1, 16'd0);
        check("t1_c1_tvalid", m_axis.tvalid, 1'b1);
        check("t1_c1_busy", busy, 1'b1);
        check("t1_c1_tlast", m_axis.tlast, 1'b0);
        check("t1_c1_tstrb", m_axis.tstrb, 32'hFFFFFFFF);
        check("t1_c1_tuser", m_axis.tuser, 128'h10000040);
        check("t1_c1_tdata", m_axis.tdata,
              256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100);
        tick();
        check("t1_c2_tlast", m_axis.tlast, 1'b1);
        check("t1_c2_tstrb", m_axis.tstrb, 32'hFFFFFFFF);
        check("t1_c2_byte0", m_axis.tdata[7:0], 8'h20);
        check("t1_c2_byte31", m_axis.tdata[255:248], 8'h3F);
        check("t1_c2_tuser", m_axis.tuser, 128'h10000040);
        tick();
        check("t1_c3_done", done, 1'b1);
        check("t1_c3_busy", busy, 1'b0);
        check("t1_c3_tvalid", m_axis.tvalid, 1'b0);
        check("t1_c3_pkts", pkts_sent, 32'd1);
        tick();
        check("t1_c4_done", done, 1'b0);

        // T2: 65 bytes, three packets, gap of 4
        pulse_start(16'd65, 32'd3, 16'd4);
        check("t2_p0_byte0", m_axis.tdata[7:0], 8'h00);
        check("t2_p0_tlast0", m_axis.tlast, 1'b0);
        tick();
        check("t2_p0_b1_byte0", m_axis.tdata[7:0], 8'h20);
        tick();
        check("t2_p0_tlast", m_axis.tlast, 1'b1);
        check("t2_p0_tstrb", m_axis.tstrb, 32'h00000001);
        check("t2_p0_tdata", m_axis.tdata, 256'h40);
        check("t2_tuser", m_axis.tuser, 128'h10000041);
        for (int g = 0; g < 4; g++) begin
            tick();
            check("t2_gap_tvalid", m_axis.tvalid, 1'b0);
            check("t2_gap_busy", busy, 1'b1);
        end
        tick();
        check("t2_p1_tvalid", m_axis.tvalid, 1'b1);
        check("t2_p1_byte0", m_axis.tdata[7:0], 8'h01);
        check("t2_p1_pkts", pkts_sent, 32'd1);
        tick();
        tick();
        check("t2_p1_tdata", m_axis.tdata, 256'h41);
        tick();
        check("t2_gap2_tvalid", m_axis.tvalid, 1'b0);
        for (int g = 0; g < 4; g++) tick();
        check("t2_p2_byte0", m_axis.tdata[7:0], 8'h02);
        tick();
        tick();
        check("t2_p2_tdata", m_axis.tdata, 256'h42);
        check("t2_p2_tlast", m_axis.tlast, 1'b1);
        tick();
        check("t2_done", done, 1'b1);
        check("t2_pkts", pkts_sent, 32'd3);
        tick();

        // T3: 100 bytes, two packets, gap 2, random backpressure
        pulse_start(16'd100, 32'd2, 16'd2);
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        prev_end   = 1'b0;
        done_seen  = 1'b0;
        beats      = 0;
        pkt_idx    = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            m_axis.tready = 1'($urandom_range(1, 0));
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (prev_valid && !prev_end) check("t3_no_drop", m_axis.tvalid, 1'b1);
                if (prev_stall) begin
                    check("t3_hold_tdata", m_axis.tdata, pd);
                    check("t3_hold_tstrb", m_axis.tstrb, ps);
                    check("t3_hold_tuser", m_axis.tuser, pu);
                    check("t3_hold_tlast", m_axis.tlast, pl);
                end
                if (m_axis.tvalid && m_axis.tready) begin
                    beats++;
                    if (m_axis.tlast) begin
                        check("t3_last_tstrb", m_axis.tstrb, 32'h0000000F);
                        check("t3_last_tdata", m_axis.tdata,
                              256'(32'h63626160 + 32'(pkt_idx) * 32'h01010101));
                        pkt_idx++;
                    end
                end
                prev_valid = m_axis.tvalid;
                prev_end   = m_axis.tready && m_axis.tlast;
                prev_stall = m_axis.tvalid && !m_axis.tready;
                pd = m_axis.tdata;
                ps = m_axis.tstrb;
                pu = m_axis.tuser;
                pl = m_axis.tlast;
                tick();
            end
        end
        check("t3_done_seen", done_seen, 1'b1);
        check("t3_beats", beats, 8);
        check("t3_pkts", pkts_sent, 32'd2);
        m_axis.tready = 1'b1;
        tick();

        // T4: continuous 60-byte packets, stop raised mid-packet
        pulse_start(16'd60, 32'd0, 16'd0);
        for (int k = 0; k < 18; k++) tick();
        check("t4_c19_tvalid", m_axis.tvalid, 1'b1);
        check("t4_c19_tlast", m_axis.tlast, 1'b0);
        check("t4_c19_pkts", pkts_sent, 32'd9);
        check("t4_c19_byte0", m_axis.tdata[7:0], 8'h09);
        stop = 1'b1;
        tick();
        check("t4_c20_tvalid", m_axis.tvalid, 1'b1);
        check("t4_c20_tlast", m_axis.tlast, 1'b1);
        check("t4_c20_tstrb", m_axis.tstrb, 32'h0FFFFFFF);
        check("t4_c20_byte0", m_axis.tdata[7:0], 8'h29);
        check("t4_c20_top", m_axis.tdata[255:224], 32'h0);
        tick();
        check("t4_done", done, 1'b1);
        check("t4_tvalid", m_axis.tvalid, 1'b0);
        check("t4_pkts", pkts_sent, 32'd10);
        stop = 1'b0;
        tick();
        check("t4_idle_tvalid", m_axis.tvalid, 1'b0);
        check("t4_idle_busy", busy, 1'b0);

        // T5: reset on beat 2 of a 10-beat frame, then restart
        pulse_start(16'd320, 32'd1, 16'd0);
        tick();
        tick();
        check("t5_beat2_byte0", m_axis.tdata[7:0], 8'h40);
        axi_reset = 1'b1;
        tick();
        check("t5_rst_tvalid", m_axis.tvalid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_pkts", pkts_sent, 32'd0);
        axi_reset = 1'b0;
        tick();
        pulse_start(16'd40, 32'd2, 16'd0);
        check("t5_p0_byte0", m_axis.tdata[7:0], 8'h00);
        check("t5_p0_tuser", m_axis.tuser, 128'h10000028);
        tick();
        check("t5_p0_tstrb", m_axis.tstrb, 32'h000000FF);
        tick();
        check("t5_p1_byte0", m_axis.tdata[7:0], 8'h01);
        tick();
        tick();
        check("t5_done", done, 1'b1);
        check("t5_pkts", pkts_sent, 32'd2);
        tick();

        // T6: start while busy is ignored; empty run pulses done only
        pulse_start(16'd64, 32'd1, 16'd0);
        pkt_len = 16'd200;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("t6_busy_tuser", m_axis.tuser, 128'h10000040);
        check("t6_busy_tlast", m_axis.tlast, 1'b1);
        tick();
        check("t6_done", done, 1'b1);
        tick();
        check("t6_no_rerun", m_axis.tvalid, 1'b0);
        pulse_start(16'd0, 32'd1, 16'd0);
        check("t6_len0_done", done, 1'b1);
        check("t6_len0_busy", busy, 1'b0);
        check("t6_len0_tvalid", m_axis.tvalid, 1'b0);
        tick();
        check("t6_len0_done_low", done, 1'b0);
        check("t6_len0_tvalid2", m_axis.tvalid, 1'b0);

        // start and stop together: exactly one packet
        stop = 1'b1;
        pulse_start(16'd64, 32'd0, 16'd3);
        check("ss_c1_tvalid", m_axis.tvalid, 1'b1);
        tick();
        check("ss_c2_tlast", m_axis.tlast, 1'b1);
        tick();
        check("ss_done", done, 1'b1);
        check("ss_pkts", pkts_sent, 32'd1);
        check("ss_tvalid", m_axis.tvalid, 1'b0);
        stop = 1'b0;
        tick();
        check("ss_idle_busy", busy, 1'b0);
        check("ss_idle_tvalid", m_axis.tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
